// File: rtl/fifo_ctrl_pkg.sv
// Shared types and width helpers for the FIFO push-arbitration control slice.
package fifo_ctrl_pkg;

    localparam int unsigned MAX_REQ      = 16;
    localparam int unsigned REQ_ID_MAX_W = 4;

    // Wide enough for any supported requester count (2..MAX_REQ).
    typedef logic [REQ_ID_MAX_W-1:0] req_id_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return ptr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_push_arb_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the last winner, wrapping;
// the priority pointer moves only when the grant is actually consumed.
module rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned REQ_ID_W = ptr_width(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                update_en,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [REQ_ID_W-1:0] gnt_idx
);

    logic [REQ_ID_W-1:0] prio_q, prio_d;
    logic [REQ_ID_W-1:0] hi_sel, lo_sel;
    logic                hi_hit, lo_hit;

    // Two ascending scans: the first request above the pointer wins, otherwise
    // the lowest request overall (the wrapped part of the rotation).
    always_comb begin
        hi_sel = '0;
        lo_sel = '0;
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !hi_hit && (i > 32'(prio_q))) begin
                hi_hit = 1'b1;
                hi_sel = REQ_ID_W'(i);
            end
            if (req[i] && !lo_hit) begin
                lo_hit = 1'b1;
                lo_sel = REQ_ID_W'(i);
            end
        end
        gnt_idx = hi_hit ? hi_sel : lo_sel;
        gnt     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt[i] = lo_hit && (gnt_idx == REQ_ID_W'(i));
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (update_en) begin
            prio_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= REQ_ID_W'(NUM_REQ - 1);
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/fifo_push_arb_ctrl.sv
// Shared-FIFO control: round-robin arbitration of the single write port plus
// ownership of the read/write pointers, occupancy count and full/empty flags.
module fifo_push_arb_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = ptr_width(DEPTH),
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned REQ_ID_W   = ptr_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_pop,
    output logic                          fifo_push,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [REQ_ID_W-1:0]           grant_id,
    output logic [ADDR_WIDTH-1:0]         wr_ptr,
    output logic [ADDR_WIDTH-1:0]         rd_ptr,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [ADDR_WIDTH:0]           fifo_count,
    output logic                          underflow_err
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  uflow_q, uflow_d;

    logic                  pop_eff;
    logic                  space;
    logic [NUM_REQ-1:0]    gnt;

    assign pop_eff   = fifo_pop && !empty_q;
    assign space     = !full_q || pop_eff;
    assign fifo_push = (|req_valid) && space;
    assign req_ready = fifo_push ? gnt : '0;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .REQ_ID_W (REQ_ID_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .update_en (fifo_push),
        .gnt       (gnt),
        .gnt_idx   (grant_id)
    );

    always_comb begin
        wr_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == REQ_ID_W'(i)) begin
                wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Flags come from the next count so they are valid the cycle after the update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        uflow_d  = uflow_q || (fifo_pop && empty_q);
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (fifo_push && !pop_eff) begin
            count_d = count_q + 1'b1;
        end else if (!fifo_push && pop_eff) begin
            count_d = count_q - 1'b1;
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            uflow_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            uflow_q  <= uflow_d;
        end
    end

    assign wr_ptr        = wr_ptr_q;
    assign rd_ptr        = rd_ptr_q;
    assign fifo_count    = count_q;
    assign fifo_full     = full_q;
    assign fifo_empty    = empty_q;
    assign underflow_err = uflow_q;

endmodule

// File: tb/tb_fifo_push_arb_ctrl.sv
// Scoreboard bench for fifo_push_arb_ctrl: expected grants/payloads are queued
// when stimulus is applied and compared against the write-port outputs.
module tb_fifo_push_arb_ctrl;

    localparam int DW    = 64;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int NR    = 4;
    localparam int IW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_pop;
    logic             fifo_push;
    logic [DW-1:0]    wr_data;
    logic [IW-1:0]    grant_id;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_count;
    logic             underflow_err;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int   m_count, m_wr, m_rd, m_last;
    bit   m_uf;

    always #5 clk = ~clk;

    fifo_push_arb_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR),
        .REQ_ID_W   (IW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_pop      (fifo_pop),
        .fifo_push     (fifo_push),
        .wr_data       (wr_data),
        .grant_id      (grant_id),
        .wr_ptr        (wr_ptr),
        .rd_ptr        (rd_ptr),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_count    (fifo_count),
        .underflow_err (underflow_err)
    );

    task automatic model_reset();
        m_count = 0;
        m_wr    = 0;
        m_rd    = 0;
        m_last  = NR - 1;
        m_uf    = 0;
        sb.delete();
    endtask

    // One cycle: drive at posedge+1, check write port at negedge, state at posedge+1.
    task automatic step(input logic [NR-1:0] v, input logic p);
        logic [NR-1:0] exp_ready;
        bit            pe, sp, push;
        int            g, pre_count;
        exp_t          e;
        req_valid = v;
        fifo_pop  = p;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {$urandom, $urandom};
        pre_count = m_count;
        pe        = p && (m_count != 0);
        sp        = (m_count != DEPTH) || pe;
        push      = (v != 0) && sp;
        g         = 0;
        exp_ready = '0;
        if (push) begin
            for (int k = 1; k <= NR; k++) begin
                int idx;
                idx = (m_last + k) % NR;
                if (v[idx]) begin
                    g = idx;
                    break;
                end
            end
            exp_ready[g] = 1'b1;
            e.id   = IW'(g);
            e.data = req_data[g*DW +: DW];
            sb.push_back(e);
        end
        @(negedge clk);
        checks++;
        if (fifo_push !== push) begin
            errors++;
            $display("FAIL fifo_push: got %b expected %b", fifo_push, push);
        end
        checks++;
        if (req_ready !== exp_ready) begin
            errors++;
            $display("FAIL req_ready: got %b expected %b", req_ready, exp_ready);
        end
        if (fifo_push === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL push_unexpected: got push with id %0d expected no push", grant_id);
            end else begin
                e = sb.pop_front();
                checks++;
                if (grant_id !== e.id) begin
                    errors++;
                    $display("FAIL grant_id: got %0d expected %0d", grant_id, e.id);
                end
                checks++;
                if (wr_data !== e.data) begin
                    errors++;
                    $display("FAIL wr_data: got %h expected %h", wr_data, e.data);
                end
            end
        end
        sb.delete();
        @(posedge clk);
        #1;
        if (push) begin
            m_wr   = (m_wr + 1) % DEPTH;
            m_count++;
            m_last = g;
        end
        if (pe) begin
            m_rd = (m_rd + 1) % DEPTH;
            m_count--;
        end
        if (p && pre_count == 0) m_uf = 1;
        checks++;
        if (fifo_count !== 7'(m_count)) begin
            errors++;
            $display("FAIL fifo_count: got %0d expected %0d", fifo_count, m_count);
        end
        checks++;
        if (wr_ptr !== AW'(m_wr) || rd_ptr !== AW'(m_rd)) begin
            errors++;
            $display("FAIL pointers: got wr=%0d rd=%0d expected wr=%0d rd=%0d", wr_ptr, rd_ptr, m_wr, m_rd);
        end
        checks++;
        if (fifo_full !== (m_count == DEPTH) || fifo_empty !== (m_count == 0)) begin
            errors++;
            $display("FAIL flags: got full=%b empty=%b expected count=%0d", fifo_full, fifo_empty, m_count);
        end
        checks++;
        if (underflow_err !== m_uf) begin
            errors++;
            $display("FAIL underflow_err: got %b expected %b", underflow_err, m_uf);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        fifo_pop  = 1'b0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_count !== '0) begin
            errors++;
            $display("FAIL reset_flags: got empty=%b full=%b count=%0d expected 1 0 0", fifo_empty, fifo_full, fifo_count);
        end
        checks++;
        if (wr_ptr !== '0 || rd_ptr !== '0 || underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ptrs: got wr=%0d rd=%0d uf=%b expected 0 0 0", wr_ptr, rd_ptr, underflow_err);
        end
        step(4'b0000, 1'b0);
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(4'b1111, 1'b0);
        checks++;
        if (fifo_full !== 1'b1 || wr_ptr !== 6'd0 || rd_ptr !== 6'd0) begin
            errors++;
            $display("FAIL fill_full: got full=%b wr=%0d rd=%0d expected 1 0 0", fifo_full, wr_ptr, rd_ptr);
        end
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
    endtask

    task automatic test_full_push_pop();
        step(4'b1111, 1'b1);
        checks++;
        if (fifo_count !== 7'd64 || fifo_full !== 1'b1 || wr_ptr !== 6'd1 || rd_ptr !== 6'd1) begin
            errors++;
            $display("FAIL full_push_pop: got count=%0d full=%b wr=%0d rd=%0d expected 64 1 1 1", fifo_count, fifo_full, wr_ptr, rd_ptr);
        end
    endtask

    task automatic test_full_pop_only();
        step(4'b0000, 1'b1);
        checks++;
        if (fifo_count !== 7'd63 || fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_only: got count=%0d full=%b expected 63 0", fifo_count, fifo_full);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        step(4'b0100, 1'b1);
        checks++;
        if (underflow_err !== 1'b1 || rd_ptr !== 6'd0 || fifo_count !== 7'd1) begin
            errors++;
            $display("FAIL underflow_push: got uf=%b rd=%0d count=%0d expected 1 0 1", underflow_err, rd_ptr, fifo_count);
        end
        step(4'b0000, 1'b1);
        repeat (3) step(4'b0000, 1'b0);
        checks++;
        if (underflow_err !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky: got %b expected 1", underflow_err);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            step(NR'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 17; i++) step(4'b1010, 1'b0);
        req_valid = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (fifo_count !== '0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 ||
            wr_ptr !== '0 || rd_ptr !== '0 || underflow_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got count=%0d empty=%b full=%b wr=%0d rd=%0d uf=%b expected 0 1 0 0 0 0",
                     fifo_count, fifo_empty, fifo_full, wr_ptr, rd_ptr, underflow_err);
        end
        checks++;
        if (grant_id !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_prio: got grant %0d expected 0", grant_id);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        model_reset();
        @(posedge clk);
        #1;
        step(4'b1111, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_push_pop();
        test_full_pop_only();
        test_underflow();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_push_arb_ctrl.md
# fifo_push_arb_ctrl

Control block for the shared FIFO. It arbitrates the single FIFO write port among `NUM_REQ` producers using round-robin, and owns the FIFO's write/read pointers, occupancy count and full/empty flags. It sits between the producer valid/ready interfaces and the FIFO storage array, which holds data only. The consumer drives `fifo_pop`. The block's pointer/flag outputs are the signals the FIFO abstraction properties are written against.

## Interface
Parameters:
- `DATA_WIDTH`, 64, payload width per entry
- `DEPTH`, 64, FIFO entries; power of two, ≥ 2
- `ADDR_WIDTH`, `$clog2(DEPTH)`, pointer width
- `NUM_REQ`, 4, number of producers; 2..16
- `REQ_ID_W`, `$clog2(NUM_REQ)`, grant index width

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  `NUM_REQ`  producer i has an entry to push
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  producer i payload in slice [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  `NUM_REQ`  push from producer i accepted this cycle; one-hot or zero
- `fifo_pop`  in  1  consumer pops the entry at `rd_ptr`
- `fifo_push`  out  1  write strobe to storage
- `wr_data`  out  `DATA_WIDTH`  granted producer's payload
- `grant_id`  out  `REQ_ID_W`  index of granted producer; valid when `fifo_push`=1
- `wr_ptr`, `rd_ptr`  out  `ADDR_WIDTH`  storage write and read addresses
- `fifo_full`, `fifo_empty`  out  1  registered occupancy flags
- `fifo_count`  out  `ADDR_WIDTH+1`  entries held, 0..DEPTH
- `underflow_err`  out  1  sticky; set by `fifo_pop` while empty

## Operation
- Reset values: `wr_ptr`=`rd_ptr`=0, `fifo_count`=0, `fifo_empty`=1, `fifo_full`=0, `underflow_err`=0, RR priority pointer=`NUM_REQ-1` (requester 0 has first priority).
- Space available: `space = !fifo_full || pop_eff`, where `pop_eff = fifo_pop && !fifo_empty`.
- Arbitration:
  - The grant goes to the first set `req_valid` bit, searching upward from (last_grant+1) mod `NUM_REQ` and wrapping.
  - `fifo_push` = any `req_valid` && `space`.
  - `req_ready[grant_id]` = `fifo_push`.
- The RR pointer updates to `grant_id` only on an accepted push. With no push, priority is unchanged.
- Accepted push: `wr_ptr` += 1 with natural wrap (DEPTH-1 → 0).
- `pop_eff`: `rd_ptr` += 1 with natural wrap.
- Pop while empty: no pointer or count change; `underflow_err` set and held until `rst`.
- Count: `fifo_count` += push − pop_eff.
  - Simultaneous push and pop_eff: count unchanged, both pointers advance.
  - Full + push + pop_eff: count stays at DEPTH, flag stays full.
- Empty + push + `fifo_pop` in the same cycle: push accepted, pop ignored (no bypass), and `underflow_err` is set.
- Flags are derived from the next count:
  - `fifo_full` = (next count == DEPTH)
  - `fifo_empty` = (next count == 0)
- Invariants the FIFO abstraction properties check:
  - `wr_ptr`==`rd_ptr` exactly when empty or full.
  - Never full and empty at once.
  - Full and no pop ⇒ full next cycle.
  - Pop with no push ⇒ not full next cycle.

## Timing
- `req_ready`, `fifo_push`, `wr_data`, `grant_id` are combinational from `req_valid`, `fifo_pop` and registered state. Zero-cycle grant.
- Pointers, count, flags and `underflow_err` are registered; they reflect a push/pop on the next rising edge.
- A producer holds `req_valid`/`req_data` until it sees `req_ready[i]`=1. The block does not buffer payloads.
- `rst` asserted mid-operation clears all state asynchronously. Storage contents are don't-care afterwards.

## Structure
- Package `fifo_ctrl_pkg`: the count/pointer width helper functions and the `req_id_t` typedef.
- Sub-module `rr_arbiter`, parameterised by `NUM_REQ`:
  - Inputs: request vector, update enable.
  - Outputs: one-hot grant and grant index.
  - Holds the priority pointer.
- The top level holds the pointer/count logic and the data mux.

## Test plan
- Reset, then idle → `fifo_empty`=1, `fifo_full`=0, `fifo_count`=0, both pointers 0, `req_ready`=0.
- All 4 producers valid continuously, no pop → grants in order 0,1,2,3,0,…. After 64 pushes: `fifo_full`=1, `wr_ptr`=0=`rd_ptr`, `req_ready`=0 until a pop.
- Full, then push and pop in the same cycle → count stays 64, `fifo_full` stays 1, both pointers advance by 1, grant rotates.
- Full, pop only → next cycle `fifo_full`=0, `fifo_count`=63.
- Empty, `fifo_pop`=1 with `req_valid[2]`=1 → `req_ready`=4'b0100, `rd_ptr` unchanged, `fifo_count`=1, `underflow_err`=1 and held.
- `rst` asserted mid-burst at count 17 → all outputs return to reset values immediately, without waiting for a clock edge.
